// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  localparam int unsigned LINE_W     = 256;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WORD_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FILL,
    RESP
  } imem_resp_state_t;

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/imem_responder_word_mux.sv
// line_word_mux: picks one 32-bit word out of a cache line by word index.
module line_word_mux
  import imem_responder_pkg::*;
(
  input  logic [LINE_W-1:0]     line_i,
  input  logic [WORD_SEL_W-1:0] sel_i,
  output logic [31:0]           word_o
);

  always_comb begin
    word_o = line_i[32*sel_i +: 32];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: serves word fetches from 4-beat burst line reads.
// Optional last-line buffer enabled by defining IMEM_LINE_BUF_EN.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  imem_resp_state_t  state_q, state_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              bmem_read_q, bmem_read_d;
  logic [31:0]       bmem_addr_q, bmem_addr_d;
  logic              imem_resp_q, imem_resp_d;
  logic [31:0]       imem_rdata_q, imem_rdata_d;
  logic [31:0]       sel_addr;
  logic [31:0]       word;
  logic              hit;
  logic              unused_req_bits;

`ifdef IMEM_LINE_BUF_EN
  logic [31-OFFSET_W:0] tag_q, tag_d;
  logic                 valid_q, valid_d;
  assign hit = valid_q && (tag_q == imem_addr[31:OFFSET_W]);
`else
  assign hit = 1'b0;
`endif

  assign unused_req_bits = ^{req_addr_q[31:OFFSET_W], req_addr_q[1:0]};

  // In IDLE the word is selected from the live request so a buffer hit can answer next cycle.
  assign sel_addr = (state_q == IDLE) ? imem_addr : req_addr_q;

  line_word_mux u_word_mux (
    .line_i (line_d),
    .sel_i  (sel_addr[OFFSET_W-1:2]),
    .word_o (word)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    bmem_read_d = bmem_read_q;
    bmem_addr_d = bmem_addr_q;
    imem_resp_d = 1'b0;
`ifdef IMEM_LINE_BUF_EN
    tag_d       = tag_q;
    valid_d     = valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (imem_rmask != '0) begin
          req_addr_d = imem_addr;
          if (hit) begin
            state_d     = RESP;
            imem_resp_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            bmem_read_d = 1'b1;
            bmem_addr_d = line_addr(imem_addr);
          end
        end
      end
      ISSUE: begin
        if (bmem_ready) begin
          bmem_read_d = 1'b0;
          cnt_d       = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (bmem_rvalid) begin
          line_d[BEAT_W*cnt_q +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS-1)) begin
            state_d     = RESP;
            imem_resp_d = 1'b1;
`ifdef IMEM_LINE_BUF_EN
            tag_d       = req_addr_q[31:OFFSET_W];
            valid_d     = 1'b1;
`endif
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    imem_rdata_d = imem_resp_d ? word : imem_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      bmem_read_q  <= 1'b0;
      bmem_addr_q  <= '0;
      imem_resp_q  <= 1'b0;
      imem_rdata_q <= '0;
`ifdef IMEM_LINE_BUF_EN
      tag_q        <= '0;
      valid_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      bmem_read_q  <= bmem_read_d;
      bmem_addr_q  <= bmem_addr_d;
      imem_resp_q  <= imem_resp_d;
      imem_rdata_q <= imem_rdata_d;
`ifdef IMEM_LINE_BUF_EN
      tag_q        <= tag_d;
      valid_q      <= valid_d;
`endif
    end
  end

  assign imem_resp  = imem_resp_q;
  assign imem_rdata = imem_rdata_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_addr  = bmem_addr_q;

`ifndef SYNTHESIS
  raddr_matches_line: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == FILL && bmem_rvalid) |-> (bmem_raddr == bmem_addr_q));
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder (honours IMEM_LINE_BUF_EN when defined).
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  imem_responder #(.BEAT_W(64), .BEATS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          gap;
    int          rdy;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs [8];
  logic [63:0] beats [4];
  int          n_cmp;
  int          n_fail;
  logic        mdl_valid;
  logic [26:0] mdl_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s resp", tag), {31'b0, imem_resp}, 32'd0);
    chk($sformatf("%s read", tag), {31'b0, bmem_read}, 32'd0);
    chk($sformatf("%s bmem_addr", tag), bmem_addr, 32'd0);
    chk($sformatf("%s rdata", tag), imem_rdata, 32'd0);
  endtask

  task automatic pulse_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mdl_valid = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after the response cycle.
  task automatic fetch(input string name, input logic [31:0] addr, input int gap,
                       input int rdy, input logic [31:0] exp_word);
    logic [31:0] line;
    bit          hit;
    line = addr & 32'hFFFF_FFE0;
`ifdef IMEM_LINE_BUF_EN
    hit = mdl_valid && (mdl_tag == addr[31:5]);
`else
    hit = 1'b0;
`endif
    imem_addr  = addr;
    imem_rmask = 4'hF;
    step();
    if (hit) begin
      chk($sformatf("%s hit resp", name), {31'b0, imem_resp}, 32'd1);
      chk($sformatf("%s hit read", name), {31'b0, bmem_read}, 32'd0);
      chk($sformatf("%s hit rdata", name), imem_rdata, exp_word);
    end else begin
      chk($sformatf("%s read", name), {31'b0, bmem_read}, 32'd1);
      chk($sformatf("%s bmem_addr", name), bmem_addr, line);
      for (int i = 0; i < rdy; i++) begin
        bmem_ready = 1'b0;
        step();
        chk($sformatf("%s hold%0d read", name, i), {31'b0, bmem_read}, 32'd1);
        chk($sformatf("%s hold%0d addr", name, i), bmem_addr, line);
        chk($sformatf("%s hold%0d resp", name, i), {31'b0, imem_resp}, 32'd0);
      end
      bmem_ready = 1'b1;
      step();
      bmem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        bmem_rvalid = 1'b0;
        for (int g = 0; g < ((k == 0) ? 1 : gap); g++) begin
          step();
          chk($sformatf("%s gap resp", name), {31'b0, imem_resp}, 32'd0);
        end
        bmem_rvalid = 1'b1;
        bmem_rdata  = beats[k];
        bmem_raddr  = line;
        step();
        bmem_rvalid = 1'b0;
        if (k < 3) chk($sformatf("%s beat%0d resp", name, k), {31'b0, imem_resp}, 32'd0);
      end
      chk($sformatf("%s resp", name), {31'b0, imem_resp}, 32'd1);
      chk($sformatf("%s rdata", name), imem_rdata, exp_word);
    end
    imem_rmask = 4'h0;
    mdl_valid  = 1'b1;
    mdl_tag    = addr[31:5];
    step();
    chk($sformatf("%s resp clear", name), {31'b0, imem_resp}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    mdl_valid = 1'b0;
    mdl_tag = '0;
    beats[0] = 64'h1111_1111_A000_0000;
    beats[1] = 64'h2222_2222_A000_0001;
    beats[2] = 64'h3333_3333_A000_0002;
    beats[3] = 64'h4444_4444_A000_0003;
    vecs[0] = '{addr: 32'h6000_0004, gap: 0, rdy: 0, exp_word: 32'h1111_1111};
    vecs[1] = '{addr: 32'h6000_0004, gap: 2, rdy: 0, exp_word: 32'h1111_1111};
    vecs[2] = '{addr: 32'h1234_567C, gap: 0, rdy: 5, exp_word: 32'h4444_4444};
    vecs[3] = '{addr: 32'h6000_0010, gap: 0, rdy: 0, exp_word: 32'hA000_0002};
    vecs[4] = '{addr: 32'h7000_0018, gap: 1, rdy: 1, exp_word: 32'hA000_0003};
    vecs[5] = '{addr: 32'h6000_000C, gap: 0, rdy: 2, exp_word: 32'h2222_2222};
    vecs[6] = '{addr: 32'h7000_0014, gap: 0, rdy: 0, exp_word: 32'h3333_3333};
    vecs[7] = '{addr: 32'h6000_0000, gap: 0, rdy: 0, exp_word: 32'hA000_0000};

    rst_n = 1'b0;
    imem_addr = '0;
    imem_rmask = 4'h0;
    bmem_ready = 1'b0;
    bmem_raddr = '0;
    bmem_rdata = '0;
    bmem_rvalid = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      fetch($sformatf("v%0d", v), vecs[v].addr, vecs[v].gap, vecs[v].rdy, vecs[v].exp_word);
    end

    // Reset during the second beat; trailing beats must be ignored.
    imem_addr = 32'h6000_0000;
    imem_rmask = 4'hF;
    step();
    bmem_ready = 1'b1;
    step();
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b1;
    bmem_rdata = beats[0];
    bmem_raddr = 32'h6000_0000;
    step();
    bmem_rdata = beats[1];
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mdl_valid = 1'b0;
    step();
    rst_n = 1'b1;
    imem_rmask = 4'h0;
    bmem_rdata = beats[2];
    step();
    chk("post-reset beat2 resp", {31'b0, imem_resp}, 32'd0);
    bmem_rdata = beats[3];
    step();
    bmem_rvalid = 1'b0;
    check_reset_outputs("post-reset");
    step();
    fetch("after reset", 32'h6000_001C, 0, 0, 32'h4444_4444);

    // rmask=0 keeps the FSM idle, even with stray beats on the bus.
    for (int i = 0; i < 10; i++) begin
      imem_addr = $urandom;
      bmem_rvalid = (i % 2) == 0;
      bmem_rdata = {$urandom, $urandom};
      bmem_raddr = 32'h6000_0000;
      step();
      chk($sformatf("idle%0d read", i), {31'b0, bmem_read}, 32'd0);
      chk($sformatf("idle%0d resp", i), {31'b0, imem_resp}, 32'd0);
    end
    bmem_rvalid = 1'b0;

`ifdef IMEM_LINE_BUF_EN
    pulse_reset();
    fetch("buf miss", 32'h6000_0000, 0, 0, 32'hA000_0000);
    fetch("buf hit", 32'h6000_0008, 0, 0, 32'hA000_0001);
    fetch("buf next line", 32'h6000_0020, 0, 0, 32'hA000_0000);
`else
    pulse_reset();
    fetch("nobuf first", 32'h6000_0000, 0, 0, 32'hA000_0000);
    fetch("nobuf repeat", 32'h6000_0008, 0, 0, 32'hA000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Responder end of the pipeline's instruction-memory port. Accepts word fetch requests (`imem_addr`/`imem_rmask`) from the fetch side and returns `imem_resp`/`imem_rdata` to the decode stage. Each fetch is served by reading a 256-bit line from the burst backing memory (`bmem_*`, four 64-bit beats). Sits between the pipeline front end and the memory model or arbiter.

## Interface
- `BEAT_W`, 64, backing-memory beat width in bits
- `BEATS`, 4, beats per line; line = `BEAT_W*BEATS` = 256 bits
- `clk`  in  1  clock; all state changes on posedge
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- `imem_addr`  in  32  fetch byte address; bits [1:0] ignored
- `imem_rmask`  in  4  nonzero = fetch request; requester holds addr/rmask stable until `imem_resp`
- `imem_rdata`  out  32  fetched instruction word; valid only when `imem_resp`=1
- `imem_resp`  out  1  one-cycle response pulse
- `bmem_addr`  out  32  line address `{addr[31:5],5'b0}`
- `bmem_read`  out  1  burst read request; held until `bmem_ready`
- `bmem_ready`  in  1  backing memory accepts the request this cycle
- `bmem_raddr`  in  32  line address of the returning beat
- `bmem_rdata`  in  64  beat data, beat 0 = line bits [63:0]
- `bmem_rvalid`  in  1  beat valid

## Operation
- FSM states: IDLE, ISSUE, FILL, RESP.
- IDLE: when `imem_rmask != 0`, capture `imem_addr` into `req_addr`, then go to ISSUE. All other inputs are ignored in IDLE, including stray `bmem_rvalid`.
- ISSUE: drive `bmem_read`=1 and `bmem_addr` = line of `req_addr`. When `bmem_ready`=1, clear the beat counter and go to FILL.
- FILL: on each `bmem_rvalid`, write `bmem_rdata` into `line[64*cnt +: 64]`, then increment the 2-bit `cnt`. When the beat with `cnt`=3 arrives, go to RESP.
- RESP: drive `imem_resp`=1 and `imem_rdata` = `line[32*req_addr[4:2] +: 32]`, then go to IDLE.
- A request that changes while the FSM is outside IDLE is a protocol violation. The block ignores it and serves the captured `req_addr`.
- `bmem_raddr` must equal the issued line address. A simulation-only assertion flags a mismatch. The data is still accepted.
- Reset values: state=IDLE, `cnt`=0, `imem_resp`=0, `imem_rdata`=0, `bmem_read`=0, `bmem_addr`=0, line data=0.

## Timing
- Miss latency: request seen in IDLE at cycle 0; `bmem_read` high from cycle 1.
  - If `bmem_ready` is high at cycle 1 and beats arrive on consecutive cycles 3..6, `imem_resp` is high at cycle 7.
  - In general, `imem_resp` is high one cycle after the fourth beat.
- Gaps between beats (`bmem_rvalid` low) stall FILL without penalty.
- A request is accepted no earlier than the cycle after RESP, so the back-to-back rate is one fetch per response plus one IDLE cycle.
- Reset asserted mid-ISSUE or mid-FILL: immediate return to reset values. Beats still arriving after release land in IDLE and are ignored. The requester re-issues its request.
- `imem_resp` is never high for two consecutive cycles.

## Configuration
- `IMEM_LINE_BUF_EN` defined:
  - Keep the last filled line plus its tag `req_addr[31:5]` and a valid bit (reset 0).
  - IDLE request whose `imem_addr[31:5]` matches the tag with valid=1: go directly to RESP, so `imem_resp` is high the next cycle and `bmem_read` is never asserted.
  - Mismatch: normal miss path. Valid is set when FILL completes and cleared by reset.
- Not defined: no tag or valid storage. Every request takes the miss path, and the line register is scratch only.

## Structure
- Shared package (alongside `rv32i_types`):
  - state enum `imem_resp_state_t` {IDLE, ISSUE, FILL, RESP}
  - localparams `LINE_W`=256, `OFFSET_W`=5, `WORD_SEL_W`=3
- One natural sub-module, `line_word_mux`: combinational selection of a 32-bit word from a 256-bit line by `addr[4:2]`. Everything else stays in `imem_responder`.

## Test plan
- Reset, then `imem_addr`=0x6000_0004, rmask=4'hF; beats 0x1111…, 0x2222…, 0x3333…, 0x4444… with ready at cycle 1 and beats at cycles 3..6:
  - `bmem_addr`=0x6000_0000
  - `imem_resp` at cycle 7
  - `imem_rdata`=upper word of beat 0
- Same address with `bmem_rvalid` gaps of 2 cycles between beats -> identical data; `imem_resp` exactly one cycle after the last beat.
- `bmem_ready` held low for 5 cycles -> `bmem_read` and `bmem_addr` stable for all 5 cycles; no `imem_resp`.
- `rst_n` pulsed low during the second beat; two more beats arrive after release -> no `imem_resp`, outputs at reset values. A new request to 0x6000_001C then completes normally, returning beat 3's upper word.
- `IMEM_LINE_BUF_EN` defined:
  - 0x6000_0000 fetched (miss), then 0x6000_0008 -> `imem_resp` one cycle after the request, `bmem_read` never asserted.
  - Then 0x6000_0020 -> miss path with `bmem_read`.
- Alternating requests with `imem_resp` checked -> never two consecutive response cycles; `rmask`=0 in IDLE keeps the FSM idle indefinitely.
